// File: rtl/priority_encoder_pkg.sv
// Shared constants for the priority encoder slice.
package priority_encoder_pkg;

    // Default request-vector width used by the top level.
    localparam int PE_DEFAULT_WIDTH = 8;

endpackage : priority_encoder_pkg

// File: rtl/priority_encoder_core.sv
// Combinational leading-one detector: index of the highest set bit of d.
// Bits are scanned LSB->MSB so the last (highest) hit overwrites earlier ones.
module priority_encoder_core #(
    parameter  int WIDTH = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] d,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan every request bit; a later (higher) set bit replaces the index.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (d[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule : priority_encoder_core

// File: rtl/priority_encoder.sv
// Registered N-to-log2(N) priority encoder. Y holds the index of the highest
// set bit of D sampled on the previous rising edge; valid flags a non-zero D.
module priority_encoder
    import priority_encoder_pkg::*;
#(
    parameter  int WIDTH = PE_DEFAULT_WIDTH,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] D,
    output logic [IDX_W-1:0] Y,
    output logic             valid
);

    logic [IDX_W-1:0] idx;
    logic             any;

    priority_encoder_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .d   (D),
        .idx (idx),
        .any (any)
    );

    // Single output stage; reset clears outputs without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y     <= '0;
            valid <= 1'b0;
        end else begin
            Y     <= idx;
            valid <= any;
        end
    end

    // A one-hot request must come back as exactly its own bit position.
    property p_onehot;
        @(posedge clk) disable iff (!rst_n)
            $onehot(D) |=> ($past(D) == (WIDTH'(1) << Y));
    endproperty
    a_onehot: assert property (p_onehot);

    // No valid request means the index must read zero.
    property p_idle_zero;
        @(posedge clk) disable iff (!rst_n) !valid |-> (Y == '0);
    endproperty
    a_idle_zero: assert property (p_idle_zero);

    // While held in reset the outputs stay cleared.
    property p_reset_vals;
        @(posedge clk) !rst_n |-> (Y == '0 && !valid);
    endproperty
    a_reset_vals: assert property (p_reset_vals);

endmodule : priority_encoder

// File: tb/tb_priority_encoder.sv
// Self-checking bench for priority_encoder (WIDTH = 8).
module tb_priority_encoder;

    localparam int WIDTH = 8;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] D;
    logic [IDX_W-1:0] Y;
    logic             valid;

    int n_cmp = 0;
    int n_err = 0;

    priority_encoder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .D     (D),
        .Y     (Y),
        .valid (valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [IDX_W-1:0] y;
        logic             v;
    } vec_t;

    vec_t vecs[12];

    // Reference: scan from the MSB down, first set bit wins.
    function automatic logic [IDX_W-1:0] ref_idx(input logic [WIDTH-1:0] d);
        for (int i = WIDTH - 1; i >= 0; i--)
            if (d[i]) return IDX_W'(i);
        return '0;
    endfunction

    task automatic check(input string name, input logic [IDX_W-1:0] ey, input logic ev);
        n_cmp++;
        if (Y !== ey || valid !== ev) begin
            n_err++;
            $display("FAIL %s: got Y=%0d valid=%0b, expected Y=%0d valid=%0b",
                     name, Y, valid, ey, ev);
        end
    endtask

    // Present d, wait one edge, sample 1 time unit later.
    task automatic step(input logic [WIDTH-1:0] d);
        D = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{8'h00, 3'd0, 1'b0};
        vecs[1]  = '{8'h01, 3'd0, 1'b1};
        vecs[2]  = '{8'h02, 3'd1, 1'b1};
        vecs[3]  = '{8'h04, 3'd2, 1'b1};
        vecs[4]  = '{8'h08, 3'd3, 1'b1};
        vecs[5]  = '{8'h10, 3'd4, 1'b1};
        vecs[6]  = '{8'h20, 3'd5, 1'b1};
        vecs[7]  = '{8'h40, 3'd6, 1'b1};
        vecs[8]  = '{8'h80, 3'd7, 1'b1};
        vecs[9]  = '{8'hC0, 3'd7, 1'b1};
        vecs[10] = '{8'h35, 3'd5, 1'b1};
        vecs[11] = '{8'hFF, 3'd7, 1'b1};

        // Reset with all requests asserted, checked before any clock edge.
        rst_n = 1'b0;
        D     = 8'hFF;
        #3;
        check("reset_pre_edge", 3'd0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held_edge", 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_released_no_edge", 3'd0, 1'b0);

        // Directed table: zero, one-hot walk, multi-hot priority.
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].d);
            check($sformatf("vec%0d_d%02h", i, vecs[i].d), vecs[i].y, vecs[i].v);
        end

        // Latency: output must still show the previous D just before the edge.
        step(8'h01);
        @(negedge clk);
        D = 8'h80;
        #1;
        check("latency_hold", 3'd0, 1'b1);
        @(posedge clk);
        #1;
        check("latency_update", 3'd7, 1'b1);

        // Mid-run async reset while streaming D = 0x40.
        step(8'h40);
        check("midrun_before_reset", 3'd6, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrun_async_clear", 3'd0, 1'b0);
        @(posedge clk);
        #1;
        check("midrun_held", 3'd0, 1'b0);
        #2;
        rst_n = 1'b1;
        #1;
        check("midrun_release_no_edge", 3'd0, 1'b0);
        @(posedge clk);
        #1;
        check("midrun_first_edge", 3'd6, 1'b1);

        // Random vectors against the reference model.
        for (int i = 0; i < 1000; i++) begin
            logic [WIDTH-1:0] r;
            r = WIDTH'($urandom);
            if (i % 7 == 0) r = '0;
            step(r);
            check($sformatf("rand%0d_d%02h", i, r), ref_idx(r), |r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute guard so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule : tb_priority_encoder
